// File: rtl/load_store_unit.sv
// Load/store unit: turns one load or store request into a req/gnt/rvalid
// data bus transaction and returns aligned, extended load data for write-back.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [2:0]            lsu_type_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_done_o,
    output logic                  lsu_err_o,
    output logic                  lsu_busy_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic                    r_we;
    logic [2:0]              r_type;
    logic [1:0]              r_off;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [3:0]              r_be;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_illegal;
    logic                    w_misaligned;
    logic [3:0]              w_be;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_load;

    // Request decode: legality, alignment and store lane steering.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = lsu_wdata_i;
        case (lsu_type_i)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            default:                w_illegal = lsu_we_i & lsu_type_i[2];
        endcase
        case (lsu_type_i[1:0])
            2'b01:   w_misaligned = lsu_addr_i[0];
            2'b10:   w_misaligned = (lsu_addr_i[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        if (lsu_we_i) begin
            case (lsu_type_i[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << lsu_addr_i[1:0];
                    w_wdata = {4{lsu_wdata_i[7:0]}};
                end
                2'b01: begin
                    w_be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{lsu_wdata_i[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = lsu_wdata_i;
                end
            endcase
        end
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        w_shifted = data_rdata_i >> {r_off, 3'b000};
        case (r_type)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (lsu_req_i) begin
                    w_next = (w_illegal || w_misaligned) ? S_ERR : S_REQ;
                end
            end
            S_REQ:   if (data_gnt_i) w_next = S_WAIT;
            S_WAIT:  if (data_rvalid_i) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        data_req_o = (r_state == S_REQ);
        lsu_done_o = (r_state == S_DONE);
        lsu_err_o  = (r_state == S_ERR);
        lsu_busy_o = (r_state != S_IDLE);
    end

    // Request fields are captured once in IDLE so the bus sees them stable until grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_type  <= 3'b000;
            r_off   <= 2'b00;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && lsu_req_i) begin
                r_we    <= lsu_we_i;
                r_type  <= lsu_type_i;
                r_off   <= lsu_addr_i[1:0];
                r_addr  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
            if (r_state == S_WAIT && data_rvalid_i && !r_we) begin
                r_rdata <= w_load;
            end
        end
    end

    assign data_addr_o  = r_addr;
    assign data_we_o    = r_we;
    assign data_be_o    = r_be;
    assign data_wdata_o = r_wdata;
    assign lsu_rdata_o  = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: hand-computed vectors for loads,
// stores, bus stalls, error pulses and mid-transaction reset.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_type_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_done_o;
    logic        lsu_err_o;
    logic        lsu_busy_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_rdata_o(lsu_rdata_o), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o),
        .lsu_busy_o(lsu_busy_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue a request with immediate grant and response; returns with the DUT in DONE.
    task automatic applyStimulus(input logic we, input logic [2:0] typ,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata);
        lsu_we_i    = we;
        lsu_type_i  = typ;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
        lsu_req_i   = 1'b1;
        data_gnt_i  = 1'b1;
        tick();
        lsu_req_i   = 1'b0;
        tick();
        data_gnt_i    = 1'b0;
        data_rdata_i  = rdata;
        data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 3'b000;
        lsu_addr_i = '0; lsu_wdata_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        data_rvalid_i = 1'b0;
        checks++;
        if ({lsu_rdata_o, lsu_done_o, lsu_err_o, lsu_busy_o, data_req_o,
             data_addr_o, data_we_o, data_be_o, data_wdata_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rdata=%h done=%b err=%b busy=%b req=%b addr=%h we=%b be=%b wdata=%h, all must be 0",
                     lsu_rdata_o, lsu_done_o, lsu_err_o, lsu_busy_o, data_req_o,
                     data_addr_o, data_we_o, data_be_o, data_wdata_o);
        end
    endtask

    task automatic test_load_word();
        lsu_we_i = 1'b0; lsu_type_i = 3'b010; lsu_addr_i = 32'h0000_1000;
        lsu_wdata_i = 32'h5555_AAAA; lsu_req_i = 1'b1; data_gnt_i = 1'b1;
        tick();
        lsu_req_i = 1'b0;
        checks++;
        if ({data_req_o, lsu_busy_o, data_we_o} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL lw_req: req/busy/we=%b expected 110", {data_req_o, lsu_busy_o, data_we_o});
        end
        checks++;
        if (data_addr_o !== 32'h0000_1000 || data_be_o !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL lw_addr_be: addr=%h be=%b expected 00001000 1111", data_addr_o, data_be_o);
        end
        tick();
        data_gnt_i = 1'b0;
        checks++;
        if (data_req_o !== 1'b0 || lsu_busy_o !== 1'b1 || lsu_done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_wait: req=%b busy=%b done=%b expected 0 1 0", data_req_o, lsu_busy_o, lsu_done_o);
        end
        data_rdata_i = 32'hDEAD_BEEF; data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
        checks++;
        if (lsu_done_o !== 1'b1 || lsu_busy_o !== 1'b1 || lsu_rdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL lw_done: done=%b busy=%b rdata=%h expected 1 1 deadbeef", lsu_done_o, lsu_busy_o, lsu_rdata_o);
        end
        tick();
        checks++;
        if (lsu_done_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_idle: done=%b busy=%b expected 0 0", lsu_done_o, lsu_busy_o);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  typ [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
        logic [31:0] adr [5] = '{32'h2003, 32'h2003, 32'h2002, 32'h2002, 32'h2001};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF,
                                 32'hFFFF_80FF, 32'h0000_0012};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, typ[i], adr[i], 32'h0, 32'h80FF_1234);
            checks++;
            if (lsu_done_o !== 1'b1 || lsu_rdata_o !== exp[i]) begin
                errors++;
                $display("[TB] FAIL load_ext[%0d]: done=%b rdata=%h expected 1 %h", i, lsu_done_o, lsu_rdata_o, exp[i]);
            end
            tick();
        end
        // leave a known value behind for the store test
        applyStimulus(1'b0, 3'b101, 32'h2002, 32'h0, 32'h80FF_1234);
        tick();
    endtask

    task automatic test_store_half();
        lsu_we_i = 1'b1; lsu_type_i = 3'b001; lsu_addr_i = 32'h0000_0102;
        lsu_wdata_i = 32'h1234_ABCD; lsu_req_i = 1'b1; data_gnt_i = 1'b1;
        tick();
        lsu_req_i = 1'b0;
        checks++;
        if (data_addr_o !== 32'h0000_0100 || data_be_o !== 4'b1100 ||
            data_wdata_o !== 32'hABCD_ABCD || data_we_o !== 1'b1 || data_req_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sh_bus: addr=%h be=%b wdata=%h we=%b req=%b expected 00000100 1100 abcdabcd 1 1",
                     data_addr_o, data_be_o, data_wdata_o, data_we_o, data_req_o);
        end
        tick();
        data_gnt_i = 1'b0; data_rdata_i = 32'h1111_1111; data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
        checks++;
        if (lsu_done_o !== 1'b1 || lsu_rdata_o !== 32'h0000_80FF) begin
            errors++;
            $display("[TB] FAIL sh_done: done=%b rdata=%h expected 1 000080ff", lsu_done_o, lsu_rdata_o);
        end
        tick();
    endtask

    task automatic test_store_byte();
        logic [3:0] expBe [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            lsu_we_i = 1'b1; lsu_type_i = 3'b000; lsu_addr_i = 32'h0000_0300 + i;
            lsu_wdata_i = 32'h7766_55A5; lsu_req_i = 1'b1; data_gnt_i = 1'b1;
            tick();
            lsu_req_i = 1'b0;
            checks++;
            if (data_be_o !== expBe[i] || data_wdata_o !== 32'hA5A5_A5A5 || data_addr_o !== 32'h0000_0300) begin
                errors++;
                $display("[TB] FAIL sb_lane[%0d]: be=%b wdata=%h addr=%h expected %b a5a5a5a5 00000300",
                         i, data_be_o, data_wdata_o, data_addr_o, expBe[i]);
            end
            tick();
            data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
            tick();
            data_rvalid_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_gnt_stall();
        lsu_we_i = 1'b1; lsu_type_i = 3'b010; lsu_addr_i = 32'h0000_0200;
        lsu_wdata_i = 32'hCAFE_F00D; lsu_req_i = 1'b1; data_gnt_i = 1'b0;
        tick();
        lsu_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_req_o !== 1'b1 || lsu_busy_o !== 1'b1 || data_addr_o !== 32'h0000_0200 ||
                data_be_o !== 4'b1111 || data_wdata_o !== 32'hCAFE_F00D) begin
                errors++;
                $display("[TB] FAIL sw_stall[%0d]: req=%b busy=%b addr=%h be=%b wdata=%h expected 1 1 00000200 1111 cafef00d",
                         i, data_req_o, lsu_busy_o, data_addr_o, data_be_o, data_wdata_o);
            end
            if (i == 3) data_gnt_i = 1'b1;
            tick();
        end
        data_gnt_i = 1'b0;
        checks++;
        if (data_req_o !== 1'b0 || lsu_busy_o !== 1'b1 || lsu_done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_after_gnt: req=%b busy=%b done=%b expected 0 1 0", data_req_o, lsu_busy_o, lsu_done_o);
        end
        data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
        checks++;
        if (lsu_done_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sw_done: done=%b expected 1", lsu_done_o);
        end
        tick();
    endtask

    task automatic test_errors();
        logic        we  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  typ [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
        logic [31:0] adr [4] = '{32'h0002, 32'h0000, 32'h0000, 32'h0005};
        for (int i = 0; i < 4; i++) begin
            lsu_we_i = we[i]; lsu_type_i = typ[i]; lsu_addr_i = adr[i];
            lsu_req_i = 1'b1; data_gnt_i = 1'b1;
            tick();
            lsu_req_i = 1'b0;
            checks++;
            if (lsu_err_o !== 1'b1 || data_req_o !== 1'b0 || lsu_done_o !== 1'b0 || lsu_busy_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL err_pulse[%0d]: err=%b req=%b done=%b busy=%b expected 1 0 0 1",
                         i, lsu_err_o, data_req_o, lsu_done_o, lsu_busy_o);
            end
            tick();
            data_gnt_i = 1'b0;
            checks++;
            if (lsu_err_o !== 1'b0 || data_req_o !== 1'b0 || lsu_done_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL err_clear[%0d]: err=%b req=%b done=%b busy=%b expected 0 0 0 0",
                         i, lsu_err_o, data_req_o, lsu_done_o, lsu_busy_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0123_4567);
        // a request held high through DONE must be ignored there
        lsu_type_i = 3'b000; lsu_addr_i = 32'h0000_0041; lsu_req_i = 1'b1;
        tick();
        checks++;
        if (lsu_busy_o !== 1'b0 || data_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_done_ignore: busy=%b req=%b expected 0 0", lsu_busy_o, data_req_o);
        end
        data_gnt_i = 1'b1;
        tick();
        lsu_req_i = 1'b0;
        checks++;
        if (data_req_o !== 1'b1 || data_addr_o !== 32'h0000_0040) begin
            errors++;
            $display("[TB] FAIL b2b_second_req: req=%b addr=%h expected 1 00000040", data_req_o, data_addr_o);
        end
        tick();
        data_gnt_i = 1'b0; data_rdata_i = 32'h0000_9A00; data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
        checks++;
        if (lsu_done_o !== 1'b1 || lsu_rdata_o !== 32'hFFFF_FF9A) begin
            errors++;
            $display("[TB] FAIL b2b_second_data: done=%b rdata=%h expected 1 ffffff9a", lsu_done_o, lsu_rdata_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        lsu_we_i = 1'b0; lsu_type_i = 3'b010; lsu_addr_i = 32'h0000_0010;
        lsu_req_i = 1'b1; data_gnt_i = 1'b1;
        tick();
        lsu_req_i = 1'b0;
        tick();
        data_gnt_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if (lsu_busy_o !== 1'b0 || data_req_o !== 1'b0 || lsu_rdata_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_state: busy=%b req=%b rdata=%h expected 0 0 00000000", lsu_busy_o, data_req_o, lsu_rdata_o);
        end
        data_rdata_i = 32'h5A5A_5A5A; data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
        checks++;
        if (lsu_done_o !== 1'b0 || lsu_busy_o !== 1'b0 || lsu_rdata_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_stale: done=%b busy=%b rdata=%h expected 0 0 00000000", lsu_done_o, lsu_busy_o, lsu_rdata_o);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store_half();
        test_store_byte();
        test_gnt_stall();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the ALU/register-file datapath and the data memory bus.
- Accepts one load or store per request. The effective address comes from the ALU result and the store data from register-file read port B.
- Performs a req/gnt/rvalid bus transaction and returns aligned, sign- or zero-extended load data. That data is the LSU write-back source selected by the write-port mux.
- Holds the core busy while the transaction is in flight.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 supported (4 byte lanes)
ADDR_WIDTH, 32, address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
lsu_req_i  in  1  start access; sampled only in IDLE
lsu_we_i  in  1  1=store, 0=load
lsu_type_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr_i  in  ADDR_WIDTH  byte address (ALU result)
lsu_wdata_i  in  DATA_WIDTH  store data (rs2)
lsu_rdata_o  out  DATA_WIDTH  extended load data to write-back mux
lsu_done_o  out  1  one-cycle completion pulse
lsu_err_o  out  1  one-cycle misaligned/illegal pulse
lsu_busy_o  out  1  state != IDLE
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_addr_o  out  ADDR_WIDTH  word-aligned address (addr[1:0]=00)
data_we_o  out  1  bus write enable
data_be_o  out  4  byte enables
data_wdata_o  out  DATA_WIDTH  lane-replicated store data
data_rvalid_i  in  1  response valid (load data / store ack)
data_rdata_i  in  DATA_WIDTH  raw read word

Behaviour:
- Reset values: all outputs 0; state is IDLE.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - When lsu_req_i=1, register we, type, addr[1:0], word address, be and wdata.
  - Legal and aligned access -> REQ. Otherwise -> ERR.
- Legality: type 011/110/111, or a store with type 1xx, is illegal.
- Misalignment: H/HU/SH with addr[0]=1; W with addr[1:0]!=0.
- REQ: data_req_o=1. data_addr_o, data_we_o, data_be_o and data_wdata_o are held stable until data_gnt_i=1, then -> WAIT.
- WAIT: data_req_o=0.
  - On data_rvalid_i=1 with a load: capture the extracted word into lsu_rdata_o. Then -> DONE.
  - On data_rvalid_i=1 with a store: lsu_rdata_o is unchanged. Then -> DONE.
- DONE: lsu_done_o=1 for one cycle, then -> IDLE. lsu_req_i is ignored in DONE.
- ERR: lsu_err_o=1 for one cycle, no bus request, lsu_rdata_o unchanged, then -> IDLE.
- Minimum latency with gnt and rvalid immediate: req sampled at T; data_req_o at T+1; rvalid at T+2; lsu_done_o at T+3.
- lsu_busy_o is high T+1 through T+3. The core stalls on lsu_req_i & ~lsu_done_o.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = 0011 << (2*addr[1]); wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
- Loads: be = 1111.
- Load extraction: shift data_rdata_i right by 8*addr[1:0]. B/H sign-extend bit 7/15. BU/HU zero-extend. W passes through.
- lsu_rdata_o holds its value until the next completed load.
- data_rvalid_i outside WAIT is ignored, including a stale response after reset. rvalid in the same cycle as gnt is not legal; the bus guarantees rvalid no earlier than the cycle after gnt.
- rst_i mid-transaction: returns to IDLE next cycle, data_req_o drops immediately, no done/err pulse.

Test Plan:
- LW, addr 0x1000, wdata X, gnt/rvalid immediate, rdata 0xDEADBEEF -> data_addr_o=0x1000, be=1111, data_req_o at T+1, lsu_done_o at T+3, lsu_rdata_o=0xDEADBEEF.
- LB at 0x2003, rdata 0x80FF1234 -> lsu_rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x2002 -> 0x000080FF.
- SH at 0x0102, wdata 0x1234ABCD -> data_addr_o=0x0100, be=1100, data_wdata_o=0xABCDABCD, data_we_o=1, done after rvalid, lsu_rdata_o unchanged.
- SW at 0x0200, gnt withheld 3 cycles -> data_req_o/addr/be/wdata stable for 4 cycles, busy high throughout, done 2 cycles after gnt.
- LW at 0x0002, and lsu_type_i=011 -> lsu_err_o pulse at T+1, data_req_o never asserted, lsu_done_o stays 0.
- rst_i asserted in WAIT with rvalid arriving the following cycle -> state IDLE, rvalid ignored, lsu_rdata_o=0, no done pulse.
